image_loader: RTL and testbench

- Holds one 28x28 MNIST image (784 x 32-bit words, 3136 bytes) in an internal RAM.
- The processor fills the RAM over an AXI4-Lite slave port.
- A `start` pulse then streams all 784 words, in address order, out of an AXI4-Stream master port (`x_*`) into the neural-net datapath.

---
 rtl/image_loader_pkg.sv | 22 ++
 rtl/image_loader_axil_slave.sv | 99 +++++++++
 rtl/image_loader.sv | 174 +++++++++++++++++
 tb/tb_image_loader.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_loader_pkg.sv
// image_loader_pkg
//   Shared constants and the stream FSM state type for the image loader.
//   NUM_WORDS words of DATA_WIDTH bits make up one 28x28 image. IMG_BYTES
//   is the byte span of the image. LAST_ADDR is the byte address of the
//   final stream beat, and END_ADDR is where r_addr parks after the stream.
package image_loader_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int NUM_WORDS  = 784;
    localparam int IMG_BYTES  = NUM_WORDS * 4;
    localparam int IDX_WIDTH  = 10;

    localparam logic [IDX_WIDTH-1:0]  NUM_WORDS_IDX = IDX_WIDTH'(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(IMG_BYTES - 4);
    localparam logic [ADDR_WIDTH-1:0] END_ADDR      = ADDR_WIDTH'(IMG_BYTES);
    localparam logic [1:0]            RESP_OKAY     = 2'b00;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_e;
endpackage

// File: rtl/image_loader_axil_slave.sv
// image_loader_axil_slave
//   AXI4-Lite handshake logic for the image RAM. It produces a one-cycle
//   write strobe (wr_en, wr_idx, wr_data, wr_strb). It also produces a read
//   index (rd_idx) and registers the word returned on rd_data into rdata_o.
//   Ports:
//     clk_i, rst_i              clock, synchronous active-high reset
//     aw*/w*/b* _i/_o           AXI4-Lite write address/data/response
//     ar*/r* _i/_o              AXI4-Lite read address/data
//     wr_en, wr_idx, wr_data,
//     wr_strb                   RAM write port (word index = addr[11:2])
//     rd_idx, rd_data           RAM read port (combinational lookup in top)
module image_loader_axil_slave
    import image_loader_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [3:0]            wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic                  wr_en,
    output logic [IDX_WIDTH-1:0]  wr_idx,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [3:0]            wr_strb,
    output logic [IDX_WIDTH-1:0]  rd_idx,
    input  logic [DATA_WIDTH-1:0] rd_data
);
    logic                  awready_q;
    logic                  bvalid_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  aw_hs;
    logic                  ar_hs;
    logic                  unused_addr_bits;

    assign aw_hs = awready_q & awvalid_i & wvalid_i;
    assign ar_hs = arready_q & arvalid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            // The ~awready_q term makes ready a single-cycle pulse. The
            // pending response (bvalid_q) blocks re-acceptance until the
            // response is consumed, and the master must present a fresh
            // awvalid before another write is taken.
            awready_q <= awvalid_i & wvalid_i & ~bvalid_q & ~awready_q;
            if (aw_hs) begin
                bvalid_q <= 1'b1;
            end else if (bready_i) begin
                bvalid_q <= 1'b0;
            end

            arready_q <= arvalid_i & ~rvalid_q & ~arready_q;
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
            end else if (rready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = awready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = RESP_OKAY;
    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = RESP_OKAY;

    assign wr_en   = aw_hs;
    assign wr_idx  = awaddr_i[11:2];
    assign wr_data = wdata_i;
    assign wr_strb = wstrb_i;
    assign rd_idx  = araddr_i[11:2];

    assign unused_addr_bits = ^{awaddr_i[ADDR_WIDTH-1:12], awaddr_i[1:0],
                                araddr_i[ADDR_WIDTH-1:12], araddr_i[1:0]};
endmodule

// File: rtl/image_loader.sv
// image_loader
//   Holds one 28x28 image (NUM_WORDS x 32-bit words) in an internal RAM.
//   The RAM is filled over AXI4-Lite. A rising edge on start streams every
//   word, in address order, out of the x_* AXI4-Stream master.
//   Ports:
//     s_axi_aclk, s_axi_areset  clock, synchronous active-high reset
//     start                     stream trigger (rising-edge detected)
//     S_AXI_*                   AXI4-Lite slave (awprot/arprot ignored)
//     x_tdata, x_tvalid,
//     x_tready                  AXI4-Stream master
//     x_tlast                   final-beat marker, present only when
//                               IMAGE_LOADER_TLAST_EN is defined
//
//   state  | meaning
//   IDLE   | no stream; r_addr holds its last value; waiting for start edge
//   STREAM | presenting RAM[r_addr>>2] on x_tdata; advance on each handshake
module image_loader
    import image_loader_pkg::*;
(
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] S_AXI_awaddr,
    input  logic [2:0]            S_AXI_awprot,
    input  logic                  S_AXI_awvalid,
    output logic                  S_AXI_awready,
    input  logic [DATA_WIDTH-1:0] S_AXI_wdata,
    input  logic [3:0]            S_AXI_wstrb,
    input  logic                  S_AXI_wvalid,
    output logic                  S_AXI_wready,
    output logic [1:0]            S_AXI_bresp,
    output logic                  S_AXI_bvalid,
    input  logic                  S_AXI_bready,
    input  logic [ADDR_WIDTH-1:0] S_AXI_araddr,
    input  logic [2:0]            S_AXI_arprot,
    input  logic                  S_AXI_arvalid,
    output logic                  S_AXI_arready,
    output logic [DATA_WIDTH-1:0] S_AXI_rdata,
    output logic [1:0]            S_AXI_rresp,
    output logic                  S_AXI_rvalid,
    input  logic                  S_AXI_rready,
    output logic [DATA_WIDTH-1:0] x_tdata,
    output logic                  x_tvalid,
    input  logic                  x_tready
`ifdef IMAGE_LOADER_TLAST_EN
    ,
    output logic                  x_tlast
`endif
);
    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    logic                  wr_en;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [3:0]            wr_strb;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;

    stream_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] r_addr, r_addr_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  start_q;
    logic                  start_rise;
    logic [IDX_WIDTH-1:0]  fetch_idx;
    logic [DATA_WIDTH-1:0] fetch_word;
    logic                  unused_prot;

    image_loader_axil_slave u_axil (
        .clk_i     (s_axi_aclk),
        .rst_i     (s_axi_areset),
        .awaddr_i  (S_AXI_awaddr),
        .awvalid_i (S_AXI_awvalid),
        .awready_o (S_AXI_awready),
        .wdata_i   (S_AXI_wdata),
        .wstrb_i   (S_AXI_wstrb),
        .wvalid_i  (S_AXI_wvalid),
        .wready_o  (S_AXI_wready),
        .bresp_o   (S_AXI_bresp),
        .bvalid_o  (S_AXI_bvalid),
        .bready_i  (S_AXI_bready),
        .araddr_i  (S_AXI_araddr),
        .arvalid_i (S_AXI_arvalid),
        .arready_o (S_AXI_arready),
        .rdata_o   (S_AXI_rdata),
        .rresp_o   (S_AXI_rresp),
        .rvalid_o  (S_AXI_rvalid),
        .rready_i  (S_AXI_rready),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
    );

    // The RAM has no reset, so image contents survive s_axi_areset.
    // Out-of-range writes are dropped here; the slave still answers OKAY.
    always_ff @(posedge s_axi_aclk) begin
        if (wr_en && (wr_idx < NUM_WORDS_IDX)) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = (rd_idx < NUM_WORDS_IDX) ? mem[rd_idx] : '0;

    // A single read port serves the stream. Before the first beat it
    // fetches the word at r_addr. While a beat is showing it fetches the
    // following word, so a handshake can load the next beat immediately.
    assign fetch_idx  = r_addr[11:2] + {{(IDX_WIDTH-1){1'b0}}, tvalid_q};
    assign fetch_word = (fetch_idx < NUM_WORDS_IDX) ? mem[fetch_idx] : '0;
    assign start_rise = start & ~start_q;

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q  <= IDLE;
            r_addr   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_addr   <= r_addr_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            start_q  <= start;
        end
    end

    always_comb begin
        state_d  = state_q;
        r_addr_d = r_addr;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        case (state_q)
            IDLE: begin
                tvalid_d = 1'b0;
                if (start_rise) begin
                    r_addr_d = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (!tvalid_q) begin
                    tdata_d  = fetch_word;
                    tvalid_d = 1'b1;
                end else if (x_tready) begin
                    if (r_addr == LAST_ADDR) begin
                        r_addr_d = END_ADDR;
                        tvalid_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        r_addr_d = r_addr + 32'd4;
                        tdata_d  = fetch_word;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign x_tdata  = tdata_q;
    assign x_tvalid = tvalid_q;

`ifdef IMAGE_LOADER_TLAST_EN
    assign x_tlast = tvalid_q & (r_addr == LAST_ADDR);
`endif

    assign unused_prot = ^{S_AXI_awprot, S_AXI_arprot};
endmodule

// File: tb/tb_image_loader.sv
module tb_image_loader;
    localparam int N_WORDS = 784;

    logic        clk;
    logic        s_axi_areset;
    logic        start;
    logic [31:0] S_AXI_awaddr;
    logic [2:0]  S_AXI_awprot;
    logic        S_AXI_awvalid;
    logic        S_AXI_awready;
    logic [31:0] S_AXI_wdata;
    logic [3:0]  S_AXI_wstrb;
    logic        S_AXI_wvalid;
    logic        S_AXI_wready;
    logic [1:0]  S_AXI_bresp;
    logic        S_AXI_bvalid;
    logic        S_AXI_bready;
    logic [31:0] S_AXI_araddr;
    logic [2:0]  S_AXI_arprot;
    logic        S_AXI_arvalid;
    logic        S_AXI_arready;
    logic [31:0] S_AXI_rdata;
    logic [1:0]  S_AXI_rresp;
    logic        S_AXI_rvalid;
    logic        S_AXI_rready;
    logic [31:0] x_tdata;
    logic        x_tvalid;
    logic        x_tready;
`ifdef IMAGE_LOADER_TLAST_EN
    logic        x_tlast;
`endif

    image_loader uut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (s_axi_areset),
        .start         (start),
        .S_AXI_awaddr  (S_AXI_awaddr),
        .S_AXI_awprot  (S_AXI_awprot),
        .S_AXI_awvalid (S_AXI_awvalid),
        .S_AXI_awready (S_AXI_awready),
        .S_AXI_wdata   (S_AXI_wdata),
        .S_AXI_wstrb   (S_AXI_wstrb),
        .S_AXI_wvalid  (S_AXI_wvalid),
        .S_AXI_wready  (S_AXI_wready),
        .S_AXI_bresp   (S_AXI_bresp),
        .S_AXI_bvalid  (S_AXI_bvalid),
        .S_AXI_bready  (S_AXI_bready),
        .S_AXI_araddr  (S_AXI_araddr),
        .S_AXI_arprot  (S_AXI_arprot),
        .S_AXI_arvalid (S_AXI_arvalid),
        .S_AXI_arready (S_AXI_arready),
        .S_AXI_rdata   (S_AXI_rdata),
        .S_AXI_rresp   (S_AXI_rresp),
        .S_AXI_rvalid  (S_AXI_rvalid),
        .S_AXI_rready  (S_AXI_rready),
        .x_tdata       (x_tdata),
        .x_tvalid      (x_tvalid),
        .x_tready      (x_tready)
`ifdef IMAGE_LOADER_TLAST_EN
        ,
        .x_tlast       (x_tlast)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference image: byte-addressed words, index taken from addr[11:2].
    logic [31:0] model_mem [N_WORDS];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int word_index(input logic [31:0] addr);
        return int'((addr >> 2) & 32'h3FF);
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        int idx = word_index(addr);
        if (idx < N_WORDS) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int idx = word_index(addr);
        return (idx < N_WORDS) ? model_mem[idx] : 32'h0;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit seen = 0;
        S_AXI_awaddr  = addr;
        S_AXI_wdata   = data;
        S_AXI_wstrb   = strb;
        S_AXI_awvalid = 1'b1;
        S_AXI_wvalid  = 1'b1;
        S_AXI_bready  = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            if (S_AXI_awready) begin
                seen = 1;
                break;
            end
        end
        check("awready_seen", 32'(seen), 32'd1);
        if (!seen) begin
            S_AXI_awvalid = 1'b0;
            S_AXI_wvalid  = 1'b0;
            return;
        end
        check("wready_with_awready", 32'(S_AXI_wready), 32'd1);
        @(posedge clk); #1;
        S_AXI_awvalid = 1'b0;
        S_AXI_wvalid  = 1'b0;
        check("awready_single_pulse", 32'(S_AXI_awready), 32'd0);
        check("bvalid_after_write", 32'(S_AXI_bvalid), 32'd1);
        check("bresp_okay", 32'(S_AXI_bresp), 32'd0);
        @(posedge clk); #1;
        check("bvalid_cleared", 32'(S_AXI_bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold, output logic [31:0] data);
        bit seen = 0;
        data = 32'h0;
        S_AXI_araddr  = addr;
        S_AXI_arvalid = 1'b1;
        S_AXI_rready  = (hold == 0);
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            if (S_AXI_arready) begin
                seen = 1;
                break;
            end
        end
        check("arready_seen", 32'(seen), 32'd1);
        if (!seen) begin
            S_AXI_arvalid = 1'b0;
            S_AXI_rready  = 1'b1;
            return;
        end
        @(posedge clk); #1;
        S_AXI_arvalid = 1'b0;
        check("arready_single_pulse", 32'(S_AXI_arready), 32'd0);
        check("rvalid_after_read", 32'(S_AXI_rvalid), 32'd1);
        check("rresp_okay", 32'(S_AXI_rresp), 32'd0);
        data = S_AXI_rdata;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("rvalid_held", 32'(S_AXI_rvalid), 32'd1);
            check("rdata_held", S_AXI_rdata, data);
        end
        S_AXI_rready = 1'b1;
        @(posedge clk); #1;
        check("rvalid_cleared", 32'(S_AXI_rvalid), 32'd0);
    endtask

    // Runs one complete stream with start held high throughout. Every
    // transferred beat is collected and compared with the reference image.
    task automatic run_stream(input bit rand_ready, input bit spot);
        logic [31:0] got[$];
        logic [31:0] pd = 32'h0;
        bit          pv = 0;
        bit          pr = 0;
        bit          pl = 0;
        int          stall_err = 0;
        int          lat = -1;
        int          mism = 0;
        int          retrig = 0;
        int          tl_cnt = 0;
        int          tl_bad = 0;
        int          spot_k[8]   = '{0, 1, 4, 5, 400, 774, 775, 783};
        int          spot_exp[8] = '{0, 4, 16, 0, 0, 0, 3100, 3132};

        x_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        start    = 1'b1;
        pr       = x_tready;
        for (int cyc = 0; cyc < 6000 && got.size() < N_WORDS; cyc++) begin
            @(posedge clk); #1;
            if (pv && pr) begin
                got.push_back(pd);
                if (pl) begin
                    tl_cnt++;
                    if (got.size() != N_WORDS) tl_bad++;
                end
            end else if (pv && !pr) begin
                if (!x_tvalid || x_tdata !== pd) stall_err++;
            end
            if (x_tvalid && lat < 0) lat = cyc + 1;
            pv = x_tvalid;
            pd = x_tdata;
`ifdef IMAGE_LOADER_TLAST_EN
            pl = x_tlast;
`endif
            x_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            pr = x_tready;
        end

        check("stream_beat_count", 32'(got.size()), 32'(N_WORDS));
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] !== model_mem[i]) begin
                if (mism == 0) $display("first differing beat %0d: 0x%08h vs 0x%08h", i, got[i], model_mem[i]);
                mism++;
            end
        end
        check("stream_data_mismatches", 32'(mism), 32'd0);
        check("stall_stability_violations", 32'(stall_err), 32'd0);
        check("first_beat_within_2_cycles", 32'(lat >= 1 && lat <= 2), 32'd1);
        check("r_addr_at_end", uut.r_addr, 32'd3136);
        check("tvalid_low_at_end", 32'(x_tvalid), 32'd0);
`ifdef IMAGE_LOADER_TLAST_EN
        check("tlast_count", 32'(tl_cnt), 32'd1);
        check("tlast_misplaced", 32'(tl_bad), 32'd0);
`endif
        if (spot && got.size() == N_WORDS) begin
            for (int s = 0; s < 8; s++) begin
                check($sformatf("beat_%0d", spot_k[s]), got[spot_k[s]], 32'(spot_exp[s]));
            end
        end

        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (x_tvalid) retrig++;
        end
        check("no_retrigger_with_start_held", 32'(retrig), 32'd0);
        check("r_addr_holds_end", uut.r_addr, 32'd3136);
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bit          found;

        vecs[0] = '{32'h0000_0020, 32'hAABB_CCDD, 4'hF,    32'hAABB_CCDD};
        vecs[1] = '{32'h0000_0020, 32'h1122_3344, 4'b0101, 32'hAA22_CC44};
        vecs[2] = '{32'h0000_0020, 32'h5566_7788, 4'b1000, 32'h5522_CC44};
        vecs[3] = '{32'h0000_0024, 32'hCAFE_F00D, 4'b0000, 32'h0000_0000};
        vecs[4] = '{32'd3136,      32'hDEAD_BEEF, 4'hF,    32'h0000_0000};
        vecs[5] = '{32'd4000,      32'hDEAD_BEEF, 4'hF,    32'h0000_0000};
        vecs[6] = '{32'd3132,      32'h1234_5678, 4'b0011, 32'h0000_5678};
        vecs[7] = '{32'h0000_1002, 32'h0BAD_BEEF, 4'hF,    32'h0BAD_BEEF};

        foreach (model_mem[i]) model_mem[i] = 32'h0;

        s_axi_areset  = 1'b1;
        start         = 1'b0;
        S_AXI_awaddr  = '0;
        S_AXI_awprot  = '0;
        S_AXI_awvalid = 1'b0;
        S_AXI_wdata   = '0;
        S_AXI_wstrb   = '0;
        S_AXI_wvalid  = 1'b0;
        S_AXI_bready  = 1'b1;
        S_AXI_araddr  = '0;
        S_AXI_arprot  = '0;
        S_AXI_arvalid = 1'b0;
        S_AXI_rready  = 1'b1;
        x_tready      = 1'b0;

        repeat (30) @(posedge clk);
        #1;
        s_axi_areset = 1'b0;
        @(posedge clk); #1;
        check("reset_awready", 32'(S_AXI_awready), 32'd0);
        check("reset_bvalid", 32'(S_AXI_bvalid), 32'd0);
        check("reset_arready", 32'(S_AXI_arready), 32'd0);
        check("reset_rvalid", 32'(S_AXI_rvalid), 32'd0);
        check("reset_rdata", S_AXI_rdata, 32'd0);
        check("reset_x_tvalid", 32'(x_tvalid), 32'd0);
        check("reset_x_tdata", x_tdata, 32'd0);
        check("reset_r_addr", uut.r_addr, 32'd0);

        // The RAM has no reset; zero it so the reference image is exact.
        for (int i = 0; i < N_WORDS; i++) axi_write(32'(4 * i), 32'h0, 4'hF);

        for (int a = 0; a <= 16; a += 4) begin
            axi_write(32'(a), 32'(a), 4'hF);
            model_write(32'(a), 32'(a), 4'hF);
        end
        for (int a = 3100; a <= 3132; a += 4) begin
            axi_write(32'(a), 32'(a), 4'hF);
            model_write(32'(a), 32'(a), 4'hF);
        end

        run_stream(1'b0, 1'b1);
        run_stream(1'b1, 1'b1);

        axi_read(32'd12, 1, d);
        check("read_addr_12", d, 32'd12);
        axi_read(32'd4000, 0, d);
        check("read_addr_4000", d, 32'd0);

        for (int i = 0; i < 8; i++) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            axi_read(vecs[i].addr, 0, d);
            check($sformatf("vec%0d_readback", i), d, vecs[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a  = 32'($urandom_range(0, 4095));
            logic [31:0] wd = $urandom;
            logic [3:0]  st = 4'($urandom_range(0, 15));
            axi_write(a, wd, st);
            model_write(a, wd, st);
        end
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a = 32'($urandom_range(0, 4095));
            axi_read(a, $urandom_range(0, 2), d);
            check($sformatf("rand_read_0x%0h", a), d, model_read(a));
        end

        // Response held while bready is low; a lingering wvalid without a
        // new awvalid must not start another write.
        S_AXI_awaddr  = 32'h28;
        S_AXI_wdata   = 32'h0000_0077;
        S_AXI_wstrb   = 4'hF;
        S_AXI_awvalid = 1'b1;
        S_AXI_wvalid  = 1'b1;
        S_AXI_bready  = 1'b0;
        found = 0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            if (S_AXI_awready) begin
                found = 1;
                break;
            end
        end
        check("hold_seq_awready_seen", 32'(found), 32'd1);
        @(posedge clk); #1;
        S_AXI_awvalid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            check("bvalid_held_without_bready", 32'(S_AXI_bvalid), 32'd1);
            check("no_accept_while_bvalid", 32'(S_AXI_awready), 32'd0);
        end
        S_AXI_bready = 1'b1;
        @(posedge clk); #1;
        check("bvalid_cleared_by_bready", 32'(S_AXI_bvalid), 32'd0);
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            check("lingering_wvalid_not_accepted", 32'(S_AXI_awready | S_AXI_bvalid), 32'd0);
        end
        S_AXI_wvalid = 1'b0;
        model_write(32'h28, 32'h77, 4'hF);
        axi_read(32'h28, 0, d);
        check("hold_seq_readback", d, 32'h77);

        // Reset in the middle of a stream, then restart from address 0.
        x_tready = 1'b1;
        start    = 1'b1;
        found    = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (uut.r_addr == 32'd400 && x_tvalid) begin
                found = 1;
                break;
            end
        end
        check("reached_r_addr_400", 32'(found), 32'd1);
        s_axi_areset = 1'b1;
        start        = 1'b0;
        @(posedge clk); #1;
        check("midstream_reset_tvalid", 32'(x_tvalid), 32'd0);
        check("midstream_reset_r_addr", uut.r_addr, 32'd0);
        @(posedge clk); #1;
        s_axi_areset = 1'b0;
        @(posedge clk); #1;
        run_stream(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
